// File: rtl/simon_seq_engine.sv
`timescale 1ns/1ps
// Simon-game sequencer: grows a random button sequence, plays it back as lamp pulses, checks the echo.
// Define SIMON_SPEEDUP_EN to shorten playback phases as the level rises.
module simon_seq_engine #(
  parameter int          BTN_W          = 2,
  parameter int          MAX_LEVEL      = 16,
  parameter int          SHOW_TICKS     = 30,
  parameter int          TIMEOUT_TICKS  = 120,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          SPEEDUP_STEP   = 2,
  parameter int          MIN_SHOW_TICKS = 8,
  localparam int         LW             = $clog2(MAX_LEVEL + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BTN_W-1:0] player_num,
  input  logic             player_pressed,
  output logic             simon_turn,
  output logic [BTN_W-1:0] simon_num,
  output logic             simon_pressed,
  output logic [LW-1:0]    level,
  output logic             game_over,
  output logic             game_won
);

  localparam int AW    = $clog2(MAX_LEVEL);
  localparam int TMAX0 = (SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS;
  localparam int TMAX  = (TMAX0 > MIN_SHOW_TICKS) ? TMAX0 : MIN_SHOW_TICKS;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_LISTEN, S_LOSE, S_WIN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_lfsr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    r_idx;
  logic [TW-1:0]    r_tmr;
  logic [BTN_W-1:0] r_mem [MAX_LEVEL];

  logic             w_lfsr_fb;
  logic [BTN_W-1:0] w_rand;
  logic [BTN_W-1:0] w_mem_rd;
  logic [TW-1:0]    w_phase_last;
  logic             w_phase_done;
  logic             w_idx_last;
  logic             w_hit;
  logic             w_timeout;

  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_rand       = r_lfsr[BTN_W-1:0];
  assign w_mem_rd     = r_mem[r_idx[AW-1:0]];
  assign w_phase_done = (r_tmr == w_phase_last);
  assign w_idx_last   = (r_idx == (r_level - LW'(1)));
  assign w_hit        = (player_num == w_mem_rd);
  assign w_timeout    = (r_tmr == TW'(TIMEOUT_TICKS - 1));

`ifdef SIMON_SPEEDUP_EN
  // Phase length follows the level; the floor is checked before subtracting so it never wraps.
  always_comb begin
    int v_red;
    int v_len;
    v_red = 0;
    v_len = SHOW_TICKS;
    if (r_level != '0) v_red = (int'(r_level) - 1) * SPEEDUP_STEP;
    if ((SHOW_TICKS <= MIN_SHOW_TICKS) || (v_red >= SHOW_TICKS - MIN_SHOW_TICKS))
      v_len = MIN_SHOW_TICKS;
    else
      v_len = SHOW_TICKS - v_red;
    w_phase_last = TW'(v_len - 1);
  end
`else
  assign w_phase_last = TW'(SHOW_TICKS - 1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_LOSE, S_WIN: if (start) w_state_nxt = S_APPEND;
      S_APPEND:              w_state_nxt = S_SHOW_ON;
      S_SHOW_ON:             if (w_phase_done) w_state_nxt = S_SHOW_OFF;
      S_SHOW_OFF:            if (w_phase_done) w_state_nxt = w_idx_last ? S_LISTEN : S_SHOW_ON;
      S_LISTEN: begin
        if (player_pressed) begin
          if (!w_hit)          w_state_nxt = S_LOSE;
          else if (w_idx_last) w_state_nxt = (r_level == LW'(MAX_LEVEL)) ? S_WIN : S_APPEND;
        end else if (w_timeout) begin
          w_state_nxt = S_LOSE;
        end
      end
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr  <= SEED;
      r_level <= '0;
      r_idx   <= '0;
      r_tmr   <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      case (r_state)
        S_IDLE, S_LOSE, S_WIN: begin
          if (start) begin
            r_level <= '0;
            r_idx   <= '0;
            r_tmr   <= '0;
          end
        end
        S_APPEND: begin
          r_level <= r_level + LW'(1);
          r_idx   <= '0;
          r_tmr   <= '0;
        end
        S_SHOW_ON: r_tmr <= w_phase_done ? '0 : r_tmr + TW'(1);
        S_SHOW_OFF: begin
          if (w_phase_done) begin
            r_tmr <= '0;
            r_idx <= w_idx_last ? '0 : r_idx + LW'(1);
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_LISTEN: begin
          if (player_pressed) begin
            r_tmr <= '0;
            if (w_hit && !w_idx_last) r_idx <= r_idx + LW'(1);
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequence storage has no reset; every slot is written before it can be read.
  always_ff @(posedge clk) begin
    if (r_state == S_APPEND) r_mem[r_level[AW-1:0]] <= w_rand;
  end

  assign simon_turn    = (r_state == S_APPEND) || (r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF);
  assign simon_pressed = (r_state == S_SHOW_ON);
  assign simon_num     = ((r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF) || (r_state == S_LISTEN))
                         ? w_mem_rd : '0;
  assign level         = r_level;
  assign game_over     = (r_state == S_LOSE) || (r_state == S_WIN);
  assign game_won      = (r_state == S_WIN);

endmodule
